// File: rtl/multicycle_controller.sv
// Multicycle sequencer for the 20-bit-instruction CPU: owns pc/ir and steps each
// instruction through FETCH, DECODE, EXEC, MEM and WB with registered control strobes.
module multicycle_controller (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [19:0] instr_in,
    input  logic        alu_zero,
    input  logic        mem_ack,
    output logic [19:0] pc,
    output logic [19:0] ir,
    output logic [2:0]  alu_op,
    output logic        alu_src,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        busy,
    output logic        halted,
    output logic        illegal,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        OP_R    = 4'd0,
        OP_ADDI = 4'd1,
        OP_LW   = 4'd2,
        OP_SW   = 4'd3,
        OP_BEQ  = 4'd4,
        OP_BNE  = 4'd5,
        OP_JMP  = 4'd6,
        OP_HALT = 4'd15
    } opcode_t;

    state_t      st;
    logic [3:0]  op_dec;
    logic [3:0]  op_exe;
    logic [19:0] pc_inc;
    logic [19:0] pc_branch;
    logic [19:0] pc_jump;
    logic        branch_taken;

    assign state = st;

    // {alu_op, alu_src} for an opcode; shared by EXEC entry and the MEM hold.
    function automatic logic [3:0] alu_ctrl(input logic [3:0] op);
        logic [3:0] c;
        c = 4'b0000;
        case (op)
            OP_R:                 c = {3'b010, 1'b0};
            OP_ADDI, OP_LW, OP_SW: c = {3'b000, 1'b1};
            OP_BEQ, OP_BNE:       c = {3'b001, 1'b0};
            default:              c = 4'b0000;
        endcase
        return c;
    endfunction

    always_comb begin
        op_dec       = instr_in[19:16];
        op_exe       = ir[19:16];
        pc_inc       = pc + 20'd1;
        pc_branch    = pc + 20'd1 + {{12{ir[7]}}, ir[7:0]};
        pc_jump      = {4'b0000, ir[15:0]};
        branch_taken = ((op_exe == OP_BEQ) && alu_zero) ||
                       ((op_exe == OP_BNE) && !alu_zero);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st         <= S_IDLE;
            pc         <= '0;
            ir         <= '0;
            alu_op     <= '0;
            alu_src    <= 1'b0;
            reg_dst    <= 1'b0;
            mem_to_reg <= 1'b0;
            reg_write  <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            // Strobes default low each cycle; the transition below re-asserts
            // whatever the next state needs, so every output is registered.
            alu_op     <= '0;
            alu_src    <= 1'b0;
            reg_dst    <= 1'b0;
            mem_to_reg <= 1'b0;
            reg_write  <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;

            case (st)
                S_IDLE: begin
                    if (start) begin
                        st   <= S_FETCH;
                        pc   <= '0;
                        busy <= 1'b1;
                    end
                end

                S_FETCH: begin
                    st <= S_DECODE;
                end

                S_DECODE: begin
                    ir <= instr_in;
                    if (op_dec == OP_HALT) begin
                        st     <= S_HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else if (op_dec > OP_JMP) begin
                        st      <= S_HALT;
                        busy    <= 1'b0;
                        halted  <= 1'b1;
                        illegal <= 1'b1;
                    end else begin
                        st                <= S_EXEC;
                        {alu_op, alu_src} <= alu_ctrl(op_dec);
                    end
                end

                S_EXEC: begin
                    case (op_exe)
                        OP_LW: begin
                            st                <= S_MEM;
                            mem_read          <= 1'b1;
                            {alu_op, alu_src} <= alu_ctrl(op_exe);
                        end
                        OP_SW: begin
                            st                <= S_MEM;
                            mem_write         <= 1'b1;
                            {alu_op, alu_src} <= alu_ctrl(op_exe);
                        end
                        OP_R, OP_ADDI: begin
                            st        <= S_WB;
                            reg_write <= 1'b1;
                            reg_dst   <= (op_exe == OP_R);
                        end
                        OP_BEQ, OP_BNE: begin
                            st <= S_FETCH;
                            pc <= branch_taken ? pc_branch : pc_inc;
                        end
                        OP_JMP: begin
                            st <= S_FETCH;
                            pc <= pc_jump;
                        end
                        default: begin
                            st <= S_FETCH;
                            pc <= pc_inc;
                        end
                    endcase
                end

                S_MEM: begin
                    if (mem_ack) begin
                        if (op_exe == OP_LW) begin
                            st         <= S_WB;
                            reg_write  <= 1'b1;
                            mem_to_reg <= 1'b1;
                        end else begin
                            st <= S_FETCH;
                            pc <= pc_inc;
                        end
                    end else begin
                        mem_read          <= (op_exe == OP_LW);
                        mem_write         <= (op_exe == OP_SW);
                        {alu_op, alu_src} <= alu_ctrl(op_exe);
                    end
                end

                S_WB: begin
                    st <= S_FETCH;
                    pc <= pc_inc;
                end

                S_HALT: begin
                    if (start) begin
                        st      <= S_FETCH;
                        pc      <= '0;
                        illegal <= 1'b0;
                        busy    <= 1'b1;
                        halted  <= 1'b0;
                    end
                end

                default: begin
                    st     <= S_IDLE;
                    busy   <= 1'b0;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-instruction expectations are
// queued when an instruction is presented and compared once it retires.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [19:0] instr_in = '0;
    logic        alu_zero = 1'b0;
    logic        mem_ack = 1'b0;
    logic [19:0] pc;
    logic [19:0] ir;
    logic [2:0]  alu_op;
    logic        alu_src;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        busy;
    logic        halted;
    logic        illegal;
    logic [2:0]  state;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .start(start), .instr_in(instr_in),
        .alu_zero(alu_zero), .mem_ack(mem_ack), .pc(pc), .ir(ir),
        .alu_op(alu_op), .alu_src(alu_src), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .busy(busy), .halted(halted),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] sig;
        int          cyc;
        int          rw;
        int          mr;
        int          mw;
        int          alu_bad;
        logic        dst;
        logic        m2r;
        logic [3:0]  aluc;
        logic [19:0] npc;
        logic [2:0]  fst;
        logic        ill;
    } rec_t;

    rec_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [19:0] mpc = '0;
    logic        ill_m = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic rec_t model(input logic [19:0] ins, input logic z, input int w,
                                   input logic [19:0] p);
        rec_t        e;
        logic [3:0]  op;
        logic [19:0] inc;
        logic [19:0] off;
        op  = ins[19:16];
        inc = p + 20'd1;
        off = {{12{ins[7]}}, ins[7:0]};
        e.sig = 64'h123; e.cyc = 3; e.rw = 0; e.mr = 0; e.mw = 0; e.alu_bad = 0;
        e.dst = 1'b0; e.m2r = 1'b0; e.aluc = 4'b0000; e.npc = inc; e.fst = 3'd1; e.ill = ill_m;
        case (op)
            4'd0: begin e.sig = 64'h1235; e.cyc = 4; e.rw = 1; e.dst = 1'b1; e.aluc = 4'b0100; end
            4'd1: begin e.sig = 64'h1235; e.cyc = 4; e.rw = 1; e.aluc = 4'b0001; end
            4'd2, 4'd3: begin
                e.aluc = 4'b0001;
                for (int i = 0; i <= w; i++) e.sig = {e.sig[59:0], 4'h4};
                if (op == 4'd2) begin
                    e.sig = {e.sig[59:0], 4'h5};
                    e.cyc = 5 + w; e.rw = 1; e.m2r = 1'b1; e.mr = w + 1;
                end else begin
                    e.cyc = 4 + w; e.mw = w + 1;
                end
            end
            4'd4: begin e.aluc = 4'b0010; if (z) e.npc = inc + off; end
            4'd5: begin e.aluc = 4'b0010; if (!z) e.npc = inc + off; end
            4'd6: e.npc = {4'h0, ins[15:0]};
            4'd15: begin e.sig = 64'h12; e.cyc = 2; e.npc = p; e.fst = 3'd6; end
            default: begin e.sig = 64'h12; e.cyc = 2; e.npc = p; e.fst = 3'd6; e.ill = 1'b1; end
        endcase
        return e;
    endfunction

    // Runs one instruction from FETCH until the DUT is back in FETCH or HALT.
    task automatic step(input logic [19:0] ins, input logic z, input int w, input logic noise);
        rec_t  e;
        rec_t  g;
        int    mem_n;
        string t;
        t = $sformatf("%05h@%05h", ins, mpc);
        check({"start_state ", t}, {61'd0, state}, 64'd1);
        check({"start_pc ", t}, {44'd0, pc}, {44'd0, mpc});
        instr_in = ins;
        alu_zero = z;
        sb.push_back(model(ins, z, w, mpc));
        g.sig = '0; g.cyc = 0; g.rw = 0; g.mr = 0; g.mw = 0; g.alu_bad = 0;
        g.dst = 1'b0; g.m2r = 1'b0; g.aluc = 4'b0000; mem_n = 0;
        while (1) begin
            g.sig = {g.sig[59:0], 1'b0, state};
            g.cyc++;
            if (reg_write) begin g.rw++; g.dst = reg_dst; g.m2r = mem_to_reg; end
            if (mem_read) g.mr++;
            if (mem_write) g.mw++;
            if (state == 3'd3) g.aluc = {alu_op, alu_src};
            if (state == 3'd4) begin
                if ({alu_op, alu_src} !== g.aluc) g.alu_bad++;
                mem_ack = (mem_n == w);
                mem_n++;
            end else begin
                mem_ack = noise;
            end
            start = noise;
            @(negedge clk);
            if (state == 3'd1 || state == 3'd6 || g.cyc >= 40) break;
        end
        start = 1'b0;
        mem_ack = 1'b0;
        e = sb.pop_front();
        check({"states ", t}, g.sig, e.sig);
        check({"cycles ", t}, 64'(g.cyc), 64'(e.cyc));
        check({"reg_write_cycles ", t}, 64'(g.rw), 64'(e.rw));
        check({"mem_read_cycles ", t}, 64'(g.mr), 64'(e.mr));
        check({"mem_write_cycles ", t}, 64'(g.mw), 64'(e.mw));
        check({"mem_alu_hold ", t}, 64'(g.alu_bad), 64'(e.alu_bad));
        check({"reg_dst ", t}, {63'd0, g.dst}, {63'd0, e.dst});
        check({"mem_to_reg ", t}, {63'd0, g.m2r}, {63'd0, e.m2r});
        check({"alu_ctrl ", t}, {60'd0, g.aluc}, {60'd0, e.aluc});
        check({"end_state ", t}, {61'd0, state}, {61'd0, e.fst});
        check({"next_pc ", t}, {44'd0, pc}, {44'd0, e.npc});
        check({"ir ", t}, {44'd0, ir}, {44'd0, ins});
        check({"illegal ", t}, {63'd0, illegal}, {63'd0, e.ill});
        check({"halted ", t}, {63'd0, halted}, {63'd0, e.fst == 3'd6});
        check({"busy ", t}, {63'd0, busy}, {63'd0, e.fst == 3'd1});
        mpc = e.npc;
        ill_m = e.ill;
    endtask

    task automatic restart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mpc = '0;
        ill_m = 1'b0;
        check("restart_state", {61'd0, state}, 64'd1);
        check("restart_pc", {44'd0, pc}, 64'd0);
        check("restart_illegal", {63'd0, illegal}, 64'd0);
        check("restart_busy", {63'd0, busy}, 64'd1);
        check("restart_halted", {63'd0, halted}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_state", {61'd0, state}, 64'd0);
        check("rst_pc", {44'd0, pc}, 64'd0);
        check("rst_ir", {44'd0, ir}, 64'd0);
        check("rst_strobes", {55'd0, alu_op, alu_src, reg_dst, mem_to_reg, reg_write,
              mem_read, mem_write}, 64'd0);
        check("rst_flags", {61'd0, busy, halted, illegal}, 64'd0);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("idle_wait", {61'd0, state}, 64'd0);

        restart();
        step(20'h0_1230, 1'b0, 0, 1'b0);       // R-type
        step(20'h6_0004, 1'b0, 0, 1'b0);       // jmp 4
        step(20'h2_1205, 1'b0, 3, 1'b0);       // lw, ack after 3 waits
        step(20'h6_000A, 1'b0, 0, 1'b0);
        step(20'h4_12FE, 1'b1, 0, 1'b0);       // beq taken -> 9
        step(20'h6_000A, 1'b0, 0, 1'b0);
        step(20'h4_12FE, 1'b0, 0, 1'b0);       // beq not taken -> 11
        step(20'h6_000A, 1'b0, 0, 1'b0);
        step(20'h5_12FE, 1'b1, 0, 1'b0);       // bne not taken
        step(20'h6_000A, 1'b0, 0, 1'b0);
        step(20'h5_12FE, 1'b0, 0, 1'b1);       // bne taken, start noise
        step(20'h3_1204, 1'b0, 2, 1'b1);       // sw with stray ack/start
        step(20'h3_1204, 1'b0, 0, 1'b0);       // ack on first MEM cycle
        step(20'h1_1205, 1'b0, 0, 1'b1);       // addi
        step(20'h6_ABCD, 1'b0, 0, 1'b0);
        step(20'h6_0000, 1'b0, 0, 1'b0);
        step(20'h4_00FE, 1'b1, 0, 1'b0);       // 0 -> 0xFFFFF
        step(20'h1_1205, 1'b0, 0, 1'b0);       // wraps to 0
        step(20'h6_0005, 1'b0, 0, 1'b0);
        step(20'h9_0000, 1'b0, 0, 1'b0);       // illegal
        instr_in = 20'h0_1230;
        repeat (3) @(negedge clk);
        check("halt_frozen_state", {61'd0, state}, 64'd6);
        check("halt_frozen_pc", {44'd0, pc}, 64'd5);
        check("halt_frozen_ir", {44'd0, ir}, 64'h9_0000);
        restart();
        step(20'h0_4560, 1'b0, 0, 1'b0);
        step(20'hF_0000, 1'b0, 0, 1'b0);       // halt
        restart();
        step(20'h6_0030, 1'b0, 0, 1'b0);

        instr_in = 20'h3_1204;
        mem_ack = 1'b0;
        for (int i = 0; i < 10 && state != 3'd4; i++) @(negedge clk);
        check("mid_mem_state", {61'd0, state}, 64'd4);
        check("mid_mem_write", {63'd0, mem_write}, 64'd1);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        check("mem_rst_write", {63'd0, mem_write}, 64'd0);
        check("mem_rst_state", {61'd0, state}, 64'd0);
        check("mem_rst_pc", {44'd0, pc}, 64'd0);
        check("mem_rst_busy", {63'd0, busy}, 64'd0);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {61'd0, state}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle sequencer for the 20-bit-instruction, 16-bit-data CPU datapath. Owns the program counter and instruction register, and steps each instruction through fetch, decode, execute, memory and writeback. Issues one-cycle control strobes to the register file, ALU control and data memory, and waits on a ready/ack handshake for data-memory access. Sits between the instruction memory and the register file/ALU/data-memory datapath, replacing the single-cycle control path.

## Interface
- No parameters; widths fixed: PC 20, instruction 20, opcode 4, alu_op 3.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; leaves IDLE/HALT and begins execution at PC 0
- instr_in  in  20  instruction memory read data; valid one cycle after pc is presented
- alu_zero  in  1  ALU result == 0, sampled in EXEC
- mem_ack  in  1  data memory done; sampled only in MEM
- pc  out  20  program counter, drives instruction memory address
- ir  out  20  instruction register; fields rd=[15:12], rs=[11:8], rt=[7:4], funct=[3:0], imm8=[7:0], target=[15:0]
- alu_op  out  3  000 add, 001 sub, 010 use funct
- alu_src  out  1  1 selects sign-extended imm8 as ALU operand B
- reg_dst  out  1  1 selects rd, 0 selects rt as write register
- mem_to_reg  out  1  1 selects memory data for writeback
- reg_write  out  1  register file write strobe
- mem_read / mem_write  out  1 each  data memory request, held until mem_ack
- busy  out  1  high in FETCH..WB
- halted  out  1  high in HALT
- illegal  out  1  sticky; set when an undefined opcode is decoded
- state  out  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6

## Operation
- Opcode = ir[19:16]:
  - 0 R-type
  - 1 addi
  - 2 lw
  - 3 sw
  - 4 beq
  - 5 bne
  - 6 jmp
  - 15 halt
  - 7–14 illegal
- Reset: state=IDLE, pc=0, ir=0, illegal=0, all strobes 0, alu_op=000, busy=0, halted=0.
- IDLE: wait for start, then go to FETCH with pc=0.
- FETCH: pc presented; go to DECODE.
- DECODE: ir <= instr_in at end of cycle. Next state:
  - halt → HALT
  - illegal → HALT with illegal=1
  - otherwise → EXEC
- EXEC, per opcode:
  - R-type: alu_op=010, alu_src=0.
  - addi, lw, sw: alu_op=000, alu_src=1.
  - beq/bne: alu_op=001, alu_src=0. Branch taken when alu_zero==1 (beq) or alu_zero==0 (bne).
  - jmp: no ALU use.
  - Next state: lw/sw → MEM; R-type/addi → WB; beq/bne/jmp → FETCH.
- MEM: hold mem_read (lw) or mem_write (sw) plus the ALU controls every cycle until mem_ack=1. On ack: lw → WB, sw → FETCH.
- WB: reg_write=1 for exactly this cycle.
  - reg_dst=1 for R-type, 0 for addi/lw.
  - mem_to_reg=1 only for lw.
  - Next state: FETCH.
- PC update, registered on the final cycle of each instruction:
  - default: pc+1
  - taken branch: pc+1+sext(imm8)
  - jmp: {4'b0, target}
  - all arithmetic modulo 2^20; 0xFFFFF+1 wraps to 0x00000
- HALT: pc and ir frozen; start restarts from pc=0 and clears illegal.
- start while busy is ignored. mem_ack outside MEM is ignored.

## Timing
- Cycles per instruction:
  - R-type/addi: 4
  - lw: 5 + wait cycles
  - sw: 4 + wait cycles
  - beq/bne/jmp: 3
  - halt/illegal: 2 to reach HALT
- Instruction memory has one-cycle read latency: pc stable in FETCH, instr_in captured at the DECODE→EXEC edge.
- All outputs are registered or decoded from state+ir only; no combinational path from mem_ack or alu_zero to any strobe.
- mem_ack in the same cycle a request first asserts completes the access; MEM then lasts 1 cycle.
- Reset in any state, including mid-MEM, takes effect at the next edge: strobes drop, state=IDLE, pc=0.
- rst_n low together with start: reset wins.

## Test plan
- Reset then start; instr_in=0x0_1230 (R-type rd=1, rs=2, rt=3, funct=0) → states 1,2,3,5; reg_write high only in WB; reg_dst=1; pc 0→1.
- lw at pc=4 with mem_ack delayed 3 cycles → mem_read high exactly 4 cycles; then WB with mem_to_reg=1; pc=5.
- beq imm8=0xFE at pc=10 with alu_zero=1 → pc=9; same with alu_zero=0 → pc=11; bne gives the opposite outcomes.
- jmp target=0xABCD → pc=0x0ABCD; addi at pc=0xFFFFF → pc wraps to 0x00000.
- Opcode 0x9 decoded → HALT with illegal=1 and halted=1; start → pc=0, illegal=0, state=FETCH.
- rst_n low during MEM with mem_write high → next edge mem_write=0, state=IDLE, pc=0; a start pulse while busy has no effect.
